sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the board's external 16-bit asynchronous SRAM (20-bit word address, byte lanes LB/UB). Two requesters, such as a write-side pattern generator and a read-back checker, each get a simple req/ack port. The block grants one request at a time, then drives the SRAM pins through a fixed setup / strobe / release sequence. It replaces ad-hoc per-test sequencing of chip_en, data_enable and output_enable.

---
 rtl/sram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port arbiter and access sequencer for an external 16-bit asynchronous
//   SRAM (20-bit word address, byte lanes LB/UB). A granted request runs a
//   fixed SETUP / ACCESS (WAIT_CYCLES) / DONE sequence on the SRAM pins.
//
//   Optional feature macro: SRAM_ARB_RR_EN
//     defined   : round-robin arbitration on contention (last_grant tracked)
//     undefined : fixed priority, port 0 always wins contention
//
// Parameters
//   WAIT_CYCLES  strobe width in cycles per access, legal range 1..15
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   req0/1, we0/1, be0/1        per-port request, write flag, byte enables
//   addr0/1, wdata0/1           per-port word address and write data
//   ack0/1                      one-cycle completion pulse per port
//   rdata                       read data, valid with ack, held until next read
//   address, bus                SRAM address pins and bidirectional data pins
//   chip_en, data_enable,       SRAM strobes, active-low
//   output_enable, LB, UB
//   grant                       index of the port being served
//
// state  | meaning
// IDLE   | no access; bus hi-Z, chip_en high, address holds last value
// SETUP  | address and chip_en asserted, write data driven
// ACCESS | data_enable (write) or output_enable (read) and byte lanes low
// DONE   | strobes released except chip_en, write data held, ack pulsed

module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [19:0] address,
  inout  wire  [15:0] bus,
  output logic        chip_en,
  output logic        data_enable,
  output logic        output_enable,
  output logic        LB,
  output logic        UB,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter runs WAIT_LOAD..0, so ACCESS lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;
  logic        any_req;
  logic        win;
  logic        drive;

  assign any_req = req0 | req1;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  always_comb begin
    if (req0 && req1) begin
      win = ~last_grant;
    end else begin
      win = ~req0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_grant <= win;
    end
  end
`else
  // Port 1 wins only when port 0 is not requesting.
  always_comb begin
    win = ~req0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are registered at grant time; nothing from the request
  // ports reaches the pins combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      address <= '0;
      cnt_q   <= '0;
      rdata   <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        grant   <= win;
        we_q    <= win ? we1 : we0;
        be_q    <= win ? be1 : be0;
        wdata_q <= win ? wdata1 : wdata0;
        address <= win ? addr1 : addr0;
      end
      if (state_q == SETUP) begin
        cnt_q <= WAIT_LOAD;
      end else if (state_q == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Capture on the last ACCESS cycle; a read with no byte lanes
      // enabled leaves rdata untouched.
      if (state_q == ACCESS && cnt_q == 4'd0 && !we_q && be_q != 2'b00) begin
        rdata <= bus;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    chip_en       = 1'b1;
    data_enable   = 1'b1;
    output_enable = 1'b1;
    LB            = 1'b1;
    UB            = 1'b1;
    ack0          = 1'b0;
    ack1          = 1'b0;
    drive         = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        chip_en = 1'b0;
        drive   = we_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        chip_en       = 1'b0;
        drive         = we_q;
        data_enable   = ~we_q;
        output_enable = we_q;
        LB            = ~be_q[0];
        UB            = ~be_q[1];
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        chip_en = 1'b0;
        drive   = we_q;
        ack0    = ~grant;
        ack1    = grant;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and drive enable decode straight from the state register, so an
  // asynchronous reset releases the pins in the same cycle.
  assign bus = drive ? wdata_q : {16{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [1:0]  be0, be1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  sel;
  logic [15:0] mem_val;

  logic [2:0]  r0, r1;
  logic [2:0]  ack0_v, ack1_v, ce_v, de_v, oe_v, lb_v, ub_v, gnt_v;
  logic [15:0] rdata_v [3];
  logic [19:0] addr_v [3];
  wire  [15:0] bus_m, bus_w1, bus_w15;

  // Only the selected instance sees the requests.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      r0[i] = req0 && (sel == 2'(i));
      r1[i] = req1 && (sel == 2'(i));
    end
  end

  sram_arbiter #(.WAIT_CYCLES(2)) u_main (
    .clk(clk), .rst_n(rst_n), .req0(r0[0]), .req1(r1[0]), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_v[0]), .ack1(ack1_v[0]), .rdata(rdata_v[0]), .address(addr_v[0]), .bus(bus_m),
    .chip_en(ce_v[0]), .data_enable(de_v[0]), .output_enable(oe_v[0]), .LB(lb_v[0]), .UB(ub_v[0]),
    .grant(gnt_v[0]));

  sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req0(r0[1]), .req1(r1[1]), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_v[1]), .ack1(ack1_v[1]), .rdata(rdata_v[1]), .address(addr_v[1]), .bus(bus_w1),
    .chip_en(ce_v[1]), .data_enable(de_v[1]), .output_enable(oe_v[1]), .LB(lb_v[1]), .UB(ub_v[1]),
    .grant(gnt_v[1]));

  sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst_n(rst_n), .req0(r0[2]), .req1(r1[2]), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_v[2]), .ack1(ack1_v[2]), .rdata(rdata_v[2]), .address(addr_v[2]), .bus(bus_w15),
    .chip_en(ce_v[2]), .data_enable(de_v[2]), .output_enable(oe_v[2]), .LB(lb_v[2]), .UB(ub_v[2]),
    .grant(gnt_v[2]));

  // SRAM model for the main instance: drives the bus while chip and output enabled.
  assign bus_m = (!ce_v[0] && !oe_v[0]) ? mem_val : {16{1'bz}};

  logic        obs_ce, obs_de, obs_oe, obs_lb, obs_ub, obs_ack0, obs_ack1;
  logic [19:0] obs_addr;
  logic [15:0] obs_bus;

  always_comb begin
    obs_ce   = ce_v[sel];
    obs_de   = de_v[sel];
    obs_oe   = oe_v[sel];
    obs_lb   = lb_v[sel];
    obs_ub   = ub_v[sel];
    obs_ack0 = ack0_v[sel];
    obs_ack1 = ack1_v[sel];
    obs_addr = addr_v[sel];
    case (sel)
      2'd1:    obs_bus = bus_w1;
      2'd2:    obs_bus = bus_w15;
      default: obs_bus = bus_m;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    checks++;
    if (act === bad) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required bus not driven with 0x%0h (t=%0t)", name, act, bad, $time);
    end
  endtask

  function automatic int cur_w();
    return (sel == 2'd1) ? 1 : ((sel == 2'd2) ? 15 : 2);
  endfunction

  typedef struct {
    int          port;
    bit          rd;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic expect_ack(input int p, input bit rd, input logic [15:0] d);
    exp_t e;
    e.port  = p;
    e.rd    = rd;
    e.rdata = d;
    sb.push_back(e);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ack0_v[0] || ack1_v[0])) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: ack0=%0b ack1=%0b, required no ack", ack0_v[0], ack1_v[0]);
      end else begin
        e = sb.pop_front();
        chk("sb_ack_port", 32'(ack1_v[0]), 32'(e.port));
        chk("sb_ack_onehot", 32'(ack0_v[0] & ack1_v[0]), 32'd0);
        chk("sb_grant", 32'(gnt_v[0]), 32'(e.port));
        if (e.rd) chk("sb_rdata", 32'(rdata_v[0]), 32'(e.rdata));
      end
    end
  end

  task automatic drive_port(input int p, input bit rq, input bit we, input logic [1:0] be,
                            input logic [19:0] a, input logic [15:0] d);
    if (p == 0) begin
      req0 = rq; we0 = we; be0 = be; addr0 = a; wdata0 = d;
    end else begin
      req1 = rq; we1 = we; be1 = be; addr1 = a; wdata1 = d;
    end
  endtask

  // One isolated access with a cycle-by-cycle pin check; called at a negedge
  // while the selected instance is idle.
  task automatic single(input int p, input bit we, input logic [1:0] be,
                        input logic [19:0] a, input logic [15:0] d, input string tag);
    int w;
    w = cur_w();
    drive_port(p, 1'b1, we, be, a, d);
    for (int c = 1; c <= w + 3; c++) begin
      bit strobe;
      @(negedge clk);
      strobe = (c >= 2) && (c <= w + 1);
      chk($sformatf("%s_c%0d_chip_en", tag, c), 32'(obs_ce), (c <= w + 2) ? 32'd0 : 32'd1);
      chk($sformatf("%s_c%0d_data_en", tag, c), 32'(obs_de), (strobe && we) ? 32'd0 : 32'd1);
      chk($sformatf("%s_c%0d_out_en", tag, c), 32'(obs_oe), (strobe && !we) ? 32'd0 : 32'd1);
      chk($sformatf("%s_c%0d_lb", tag, c), 32'(obs_lb), (strobe && be[0]) ? 32'd0 : 32'd1);
      chk($sformatf("%s_c%0d_ub", tag, c), 32'(obs_ub), (strobe && be[1]) ? 32'd0 : 32'd1);
      chk($sformatf("%s_c%0d_ack", tag, c), 32'(p == 0 ? obs_ack0 : obs_ack1),
          (c == w + 2) ? 32'd1 : 32'd0);
      chk($sformatf("%s_c%0d_ack_other", tag, c), 32'(p == 0 ? obs_ack1 : obs_ack0), 32'd0);
      chk($sformatf("%s_c%0d_address", tag, c), 32'(obs_addr), 32'(a));
      if (we && c <= w + 2)
        chk($sformatf("%s_c%0d_bus", tag, c), 32'(obs_bus), 32'(d));
      else if (strobe && !we)
        chk($sformatf("%s_c%0d_bus_sram", tag, c), 32'(obs_bus), 32'(mem_val));
      else
        chk_ne($sformatf("%s_c%0d_bus_hiz", tag, c), 32'(obs_bus), 32'(d));
      if (c == w + 2) drive_port(p, 1'b0, we, be, a, d);
    end
  endtask

  // Back-to-back requester: holds req across acks for n accesses.
  task automatic run_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int cyc;
      bit got;
      cyc = 0;
      got = 1'b0;
      if (p == 0) drive_port(0, 1'b1, 1'b1, 2'b11, 20'(100 + k), 16'(16'h0A00 + k));
      else        drive_port(1, 1'b1, 1'b0, 2'b11, 20'(200 + k), 16'hBEEF);
      while (!got && cyc < 200) begin
        @(negedge clk);
        cyc++;
        got = (p == 0) ? ack0_v[0] : ack1_v[0];
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL port%0d_timeout: no ack within %0d cycles for access %0d", p, cyc, k);
      end
    end
    drive_port(p, 1'b0, 1'b0, 2'b00, 20'd0, 16'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sel = 2'd0;
    mem_val = 16'd0;
    drive_port(0, 1'b0, 1'b0, 2'b00, 20'd0, 16'd0);
    drive_port(1, 1'b0, 1'b0, 2'b00, 20'd0, 16'd0);
    repeat (3) @(negedge clk);

    chk("rst_address", 32'(addr_v[0]), 32'd0);
    chk("rst_rdata", 32'(rdata_v[0]), 32'd0);
    chk("rst_ack0", 32'(ack0_v[0]), 32'd0);
    chk("rst_ack1", 32'(ack1_v[0]), 32'd0);
    chk("rst_grant", 32'(gnt_v[0]), 32'd0);
    chk("rst_chip_en", 32'(ce_v[0]), 32'd1);
    chk("rst_data_en", 32'(de_v[0]), 32'd1);
    chk("rst_out_en", 32'(oe_v[0]), 32'd1);
    chk("rst_lb", 32'(lb_v[0]), 32'd1);
    chk("rst_ub", 32'(ub_v[0]), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    expect_ack(0, 1'b0, 16'd0);
    single(0, 1'b1, 2'b11, 20'd233, 16'd1024, "wr");

    mem_val = 16'd1024;
    expect_ack(1, 1'b1, 16'd1024);
    single(1, 1'b0, 2'b11, 20'd233, 16'hBEEF, "rd");

    expect_ack(0, 1'b0, 16'd0);
    single(0, 1'b1, 2'b01, 20'd5, 16'h1234, "be01");
    expect_ack(0, 1'b0, 16'd0);
    single(0, 1'b1, 2'b00, 20'd6, 16'h5678, "be00");
    chk("rdata_held_after_writes", 32'(rdata_v[0]), 32'd1024);

    mem_val = 16'h7777;
    expect_ack(1, 1'b1, 16'd1024);
    single(1, 1'b0, 2'b00, 20'd7, 16'hBEEF, "rd_be00");

    mem_val = 16'h4321;
`ifdef SRAM_ARB_RR_EN
    expect_ack(0, 1'b0, 16'd0);
    expect_ack(1, 1'b1, 16'h4321);
    expect_ack(0, 1'b0, 16'd0);
    expect_ack(1, 1'b1, 16'h4321);
    expect_ack(0, 1'b0, 16'd0);
    expect_ack(1, 1'b1, 16'h4321);
`else
    expect_ack(0, 1'b0, 16'd0);
    expect_ack(0, 1'b0, 16'd0);
    expect_ack(0, 1'b0, 16'd0);
    expect_ack(1, 1'b1, 16'h4321);
    expect_ack(1, 1'b1, 16'h4321);
    expect_ack(1, 1'b1, 16'h4321);
`endif
    fork
      run_port(0, 3);
      run_port(1, 3);
    join
    @(negedge clk);

    // Reset in the middle of a write strobe.
    drive_port(0, 1'b1, 1'b1, 2'b11, 20'd300, 16'h3C3C);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pre_data_en", 32'(de_v[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_data_en", 32'(de_v[0]), 32'd1);
    chk("rstmid_chip_en", 32'(ce_v[0]), 32'd1);
    chk("rstmid_out_en", 32'(oe_v[0]), 32'd1);
    chk("rstmid_lb", 32'(lb_v[0]), 32'd1);
    chk("rstmid_ub", 32'(ub_v[0]), 32'd1);
    chk_ne("rstmid_bus_hiz", 32'(bus_m), 32'h3C3C);
    chk("rstmid_address", 32'(addr_v[0]), 32'd0);
    drive_port(0, 1'b0, 1'b0, 2'b00, 20'd0, 16'd0);
    @(negedge clk);
    chk("rstmid_ack0", 32'(ack0_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstpost_c%0d_chip_en", i), 32'(ce_v[0]), 32'd1);
      chk($sformatf("rstpost_c%0d_ack0", i), 32'(ack0_v[0]), 32'd0);
    end
    chk("rstpost_rdata", 32'(rdata_v[0]), 32'd0);

    sel = 2'd1;
    @(negedge clk);
    single(0, 1'b1, 2'b11, 20'd9, 16'h0F0F, "w1");
    sel = 2'd2;
    @(negedge clk);
    single(0, 1'b1, 2'b10, 20'd10, 16'hF0F0, "w15");
    sel = 2'd0;
    @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
